// File: rtl/ch_arb_pkg.sv
// Shared types and constants for the channel-descriptor arbiter.
// Holds the FSM state encoding, the table entry layout and the burst length helper.
package ch_arb_pkg;

   localparam int unsigned PRIO_W      = 4;
   localparam int unsigned SIZE_W      = 32;
   localparam int unsigned BURST_BEATS = 16;
   localparam int unsigned BEATS_W     = 5;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      GRANT,
      WAIT_BURST,
      RETIRE
   } arb_state_e;

   typedef struct packed {
      logic              valid;
      logic [PRIO_W-1:0] prio;
      logic [SIZE_W-1:0] remaining;
   } ch_entry_t;

   function automatic logic [BEATS_W-1:0] burst_len(input logic [SIZE_W-1:0] rem);
      burst_len = (rem > SIZE_W'(BURST_BEATS)) ? BEATS_W'(BURST_BEATS) : rem[BEATS_W-1:0];
   endfunction

endpackage

// File: rtl/rr_prio_select.sv
// Combinational picker: highest priority among valid channels, ties broken by
// the first valid index found when scanning upward from rr_ptr_i with wrap.
module rr_prio_select
   import ch_arb_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 32,
   parameter int unsigned ID_W         = 6
) (
   input  logic [NUM_CHANNELS-1:0]             valid_i,
   input  logic [NUM_CHANNELS-1:0][PRIO_W-1:0] prio_i,
   input  logic [ID_W-1:0]                     rr_ptr_i,
   output logic                                any_valid_o,
   output logic [ID_W-1:0]                     sel_o
);

   localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   logic [PRIO_W-1:0] best;
   logic [IDX_W-1:0]  ix;

   // Strict '>' keeps the earliest candidate in scan order on a priority tie.
   always_comb begin
      any_valid_o = 1'b0;
      sel_o       = '0;
      best        = '0;
      ix          = '0;
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
         ix = IDX_W'((32'(rr_ptr_i) + k) % NUM_CHANNELS);
         if (valid_i[ix] && (!any_valid_o || (prio_i[ix] > best))) begin
            any_valid_o = 1'b1;
            best        = prio_i[ix];
            sel_o       = ID_W'(ix);
         end
      end
   end

endmodule

// File: rtl/ch_desc_arbiter.sv
// Channel descriptor table plus burst arbiter: captures descriptors, grants
// up to BURST_BEATS beats at a time and retires channels as they drain.
module ch_desc_arbiter
   import ch_arb_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 32,
   parameter int unsigned ID_W         = 6
) (
   input  logic               AXI_aclk,
   input  logic               AXI_areset,
   input  logic               arbSample,
   input  logic [ID_W-1:0]    arbCurrentChannelSample,
   input  logic [PRIO_W-1:0]  arbChannelPriority,
   input  logic [SIZE_W-1:0]  arbChannelTransferSize,
   input  logic               arbitrate,
   output logic               grant_valid,
   output logic [ID_W-1:0]    grant_ch,
   output logic [BEATS_W-1:0] grant_beats,
   input  logic               grant_ready,
   input  logic               burst_done,
   output logic               ch_done,
   output logic [ID_W-1:0]    ch_id,
   output logic               arbWriteTransactionsDone,
   output logic               sample_conflict
);

   localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   arb_state_e      state_q, state_d;
   logic            run_q, run_d;
   logic [ID_W-1:0] sel_q, sel_d;
   logic [ID_W-1:0] rr_q, rr_d;
   logic            conflict_q, conflict_d;
   ch_entry_t       tbl_q [NUM_CHANNELS];

   logic [NUM_CHANNELS-1:0]             valid_vec;
   logic [NUM_CHANNELS-1:0][PRIO_W-1:0] prio_vec;
   logic                                any_valid;
   logic [ID_W-1:0]                     pick;
   logic [IDX_W-1:0]                    pick_idx, sel_idx, smp_idx;
   logic                                busy, smp_oob, smp_accept;
   logic [BEATS_W-1:0]                  beats;
   logic [SIZE_W-1:0]                   rem_new;
   logic                                rem_wr, retire;

   always_comb begin
      valid_vec = '0;
      prio_vec  = '0;
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
         valid_vec[i] = tbl_q[i].valid;
         prio_vec[i]  = tbl_q[i].prio;
      end
   end

   rr_prio_select #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .ID_W         (ID_W)
   ) u_select (
      .valid_i     (valid_vec),
      .prio_i      (prio_vec),
      .rr_ptr_i    (rr_q),
      .any_valid_o (any_valid),
      .sel_o       (pick)
   );

   assign pick_idx = pick[IDX_W-1:0];
   assign sel_idx  = sel_q[IDX_W-1:0];
   assign smp_idx  = arbCurrentChannelSample[IDX_W-1:0];
   assign beats    = burst_len(tbl_q[sel_idx].remaining);
   assign rem_new  = tbl_q[sel_idx].remaining - SIZE_W'(beats);

   // The selected entry is frozen from GRANT through RETIRE, so samples to it are dropped.
   assign busy       = (state_q == GRANT) || (state_q == WAIT_BURST) || (state_q == RETIRE);
   assign smp_oob    = {1'b0, arbCurrentChannelSample} >= (ID_W+1)'(NUM_CHANNELS);
   assign conflict_d = arbSample && (smp_oob || (busy && (arbCurrentChannelSample == sel_q)));
   assign smp_accept = arbSample && !conflict_d;

   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      rem_wr  = 1'b0;
      retire  = 1'b0;
      if (arbitrate && !run_q) run_d = 1'b1;
      case (state_q)
         IDLE: begin
            if (run_q || arbitrate) state_d = SELECT;
         end
         SELECT: begin
            if (!any_valid) begin
               run_d   = 1'b0;
               state_d = IDLE;
            end else begin
               sel_d   = pick;
               state_d = (tbl_q[pick_idx].remaining == '0) ? RETIRE : GRANT;
            end
         end
         GRANT: begin
            if (grant_ready) state_d = WAIT_BURST;
         end
         WAIT_BURST: begin
            if (burst_done) begin
               rem_wr  = 1'b1;
               rr_d    = (sel_q >= ID_W'(NUM_CHANNELS - 1)) ? '0 : sel_q + ID_W'(1);
               state_d = (rem_new == '0) ? RETIRE : SELECT;
            end
         end
         RETIRE: begin
            retire  = 1'b1;
            state_d = SELECT;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge AXI_aclk) begin
      if (AXI_areset) begin
         state_q    <= IDLE;
         run_q      <= 1'b0;
         sel_q      <= '0;
         rr_q       <= '0;
         conflict_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_CHANNELS; i++) tbl_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         sel_q      <= sel_d;
         rr_q       <= rr_d;
         conflict_q <= conflict_d;
         if (rem_wr) tbl_q[sel_idx].remaining <= rem_new;
         if (retire) tbl_q[sel_idx].valid <= 1'b0;
         if (smp_accept) begin
            tbl_q[smp_idx] <= '{valid:     1'b1,
                                prio:      arbChannelPriority,
                                remaining: arbChannelTransferSize};
         end
      end
   end

   assign grant_valid              = (state_q == GRANT);
   assign grant_ch                 = grant_valid ? sel_q : '0;
   assign grant_beats              = grant_valid ? beats : '0;
   assign ch_done                  = (state_q == RETIRE);
   assign ch_id                    = ch_done ? sel_q : '0;
   assign arbWriteTransactionsDone = (state_q == SELECT) && !any_valid;
   assign sample_conflict          = conflict_q;

endmodule

// File: tb/tb_ch_desc_arbiter.sv
// Self-checking bench for ch_desc_arbiter: directed scenarios, a conflict vector
// table and randomized runs compared with a queue-level reference model.
module tb_ch_desc_arbiter;

   localparam int unsigned NCH    = 32;
   localparam int unsigned BUDGET = 3000;

   logic        AXI_aclk = 1'b0;
   logic        AXI_areset, arbSample, arbitrate, grant_ready, burst_done;
   logic [5:0]  arbCurrentChannelSample;
   logic [3:0]  arbChannelPriority;
   logic [31:0] arbChannelTransferSize;
   logic        grant_valid, ch_done, arbWriteTransactionsDone, sample_conflict;
   logic [5:0]  grant_ch, ch_id;
   logic [4:0]  grant_beats;

   always #5 AXI_aclk = ~AXI_aclk;

   ch_desc_arbiter #(.NUM_CHANNELS(32), .ID_W(6)) dut (
      .AXI_aclk                 (AXI_aclk),
      .AXI_areset               (AXI_areset),
      .arbSample                (arbSample),
      .arbCurrentChannelSample  (arbCurrentChannelSample),
      .arbChannelPriority       (arbChannelPriority),
      .arbChannelTransferSize   (arbChannelTransferSize),
      .arbitrate                (arbitrate),
      .grant_valid              (grant_valid),
      .grant_ch                 (grant_ch),
      .grant_beats              (grant_beats),
      .grant_ready              (grant_ready),
      .burst_done               (burst_done),
      .ch_done                  (ch_done),
      .ch_id                    (ch_id),
      .arbWriteTransactionsDone (arbWriteTransactionsDone),
      .sample_conflict          (sample_conflict)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int got_gch[$], got_gb[$], got_done[$];
   int exp_gch[$], exp_gb[$], exp_done[$];
   int first_grant_cyc, last_done_cyc, drain_cyc, lat_err, stab_err;

   // Reference model state: descriptor table and round-robin pointer.
   bit          m_v   [NCH];
   int unsigned m_p   [NCH];
   int unsigned m_rem [NCH];
   int unsigned m_rr;

   typedef struct {
      int unsigned id;
      int unsigned prio;
      int unsigned size;
      bit          exp_conf;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge AXI_aclk);
      #1;
   endtask

   task automatic clear_inputs();
      arbSample = 1'b0; arbitrate = 1'b0; grant_ready = 1'b0; burst_done = 1'b0;
      arbCurrentChannelSample = '0; arbChannelPriority = '0; arbChannelTransferSize = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      AXI_areset = 1'b1;
      tick();
      AXI_areset = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_v[i] = 0; m_p[i] = 0; m_rem[i] = 0; end
      m_rr = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " grant_valid"}, grant_valid, 0);
      check({tag, " grant_ch"}, grant_ch, 0);
      check({tag, " grant_beats"}, grant_beats, 0);
      check({tag, " ch_done"}, ch_done, 0);
      check({tag, " ch_id"}, ch_id, 0);
      check({tag, " drain"}, arbWriteTransactionsDone, 0);
      check({tag, " sample_conflict"}, sample_conflict, 0);
   endtask

   task automatic model_sample(input int unsigned id, input int unsigned prio, input int unsigned size);
      if (id < NCH) begin m_v[id] = 1; m_p[id] = prio; m_rem[id] = size; end
   endtask

   task automatic drive_sample(input int unsigned id, input int unsigned prio, input int unsigned size);
      arbSample = 1'b1;
      arbCurrentChannelSample = 6'(id);
      arbChannelPriority = 4'(prio);
      arbChannelTransferSize = size;
      tick();
      arbSample = 1'b0;
   endtask

   // Expected grant/retire order: repeatedly take the highest priority, nearest
   // distance from the pointer, and carve the transfer into 16-beat bursts.
   task automatic model_run();
      int best, bestd, d, b;
      exp_gch.delete(); exp_gb.delete(); exp_done.delete();
      forever begin
         best = -1; bestd = 0;
         for (int i = 0; i < NCH; i++) begin
            if (m_v[i]) begin
               d = (i + NCH - int'(m_rr)) % NCH;
               if (best < 0 || m_p[i] > m_p[best] || (m_p[i] == m_p[best] && d < bestd)) begin
                  best = i; bestd = d;
               end
            end
         end
         if (best < 0) break;
         if (m_rem[best] == 0) begin
            exp_done.push_back(best); m_v[best] = 0;
         end else begin
            b = (m_rem[best] > 16) ? 16 : int'(m_rem[best]);
            exp_gch.push_back(best); exp_gb.push_back(b);
            m_rem[best] -= b;
            m_rr = (best + 1) % NCH;
            if (m_rem[best] == 0) begin exp_done.push_back(best); m_v[best] = 0; end
         end
      end
   endtask

   // Emulates the transfer engine until the drain pulse or the cycle budget runs out.
   task automatic run_engine(input bit do_arb, input int unsigned rdy_max, input int unsigned bd_min,
                             input int unsigned bd_max, input bit inject, input bit spurious,
                             output bit drained);
      bit offered, busy, retired_since;
      int unsigned rdy_cnt, bd_cnt, inj;
      int bd_cyc;
      int h_ch, h_b;
      got_gch.delete(); got_gb.delete(); got_done.delete();
      first_grant_cyc = -1; last_done_cyc = -1; drain_cyc = -1; lat_err = 0; stab_err = 0;
      drained = 0; offered = 0; busy = 0; retired_since = 0; inj = 0; bd_cyc = -1;
      rdy_cnt = 0; bd_cnt = 0; h_ch = 0; h_b = 0;
      for (int cyc = 0; cyc < int'(BUDGET) && !drained; cyc++) begin
         clear_inputs();
         arbitrate = do_arb && (cyc == 0);
         if (ch_done) begin got_done.push_back(int'(ch_id)); last_done_cyc = cyc; retired_since = 1; end
         if (arbWriteTransactionsDone) begin drained = 1; drain_cyc = cyc; end
         if (!busy && grant_valid) begin
            if (!offered) begin
               offered = 1; h_ch = int'(grant_ch); h_b = int'(grant_beats);
               got_gch.push_back(h_ch); got_gb.push_back(h_b);
               rdy_cnt = $urandom_range(rdy_max, 0);
               if (first_grant_cyc < 0) first_grant_cyc = cyc;
               if (bd_cyc >= 0 && !retired_since && cyc != bd_cyc + 2) lat_err++;
               bd_cyc = -1;
            end else if (int'(grant_ch) != h_ch || int'(grant_beats) != h_b) stab_err++;
            if (rdy_cnt == 0) begin
               grant_ready = 1'b1; busy = 1; offered = 0;
               bd_cnt = $urandom_range(bd_max, bd_min);
            end else rdy_cnt--;
         end else if (busy) begin
            if (inject) begin
               if (inj == 0) begin
                  arbSample = 1'b1; arbCurrentChannelSample = 6'd3;
                  arbChannelPriority = 4'd7; arbChannelTransferSize = 32'd100;
               end else if (inj == 1) begin
                  check("S5 same-channel sample conflict", sample_conflict, 1);
                  arbSample = 1'b1; arbCurrentChannelSample = 6'd9;
                  arbChannelPriority = 4'd1; arbChannelTransferSize = 32'd5;
               end else if (inj == 2) begin
                  check("S5 other-channel sample accepted", sample_conflict, 0);
               end
               if (inj < 3) inj++;
            end
            if (bd_cnt == 0) begin
               burst_done = 1'b1; busy = 0; bd_cyc = cyc; retired_since = 0;
            end else bd_cnt--;
         end else if (spurious && $urandom_range(3, 0) == 0) begin
            burst_done = 1'b1;
         end
         if (!drained) tick();
      end
      clear_inputs();
   endtask

   task automatic check_run(input string tag, input bit drained);
      check({tag, " drained within budget"}, drained, 1);
      check({tag, " grant count"}, got_gch.size(), exp_gch.size());
      for (int i = 0; i < exp_gch.size() && i < got_gch.size(); i++) begin
         check($sformatf("%s grant%0d ch", tag, i), got_gch[i], exp_gch[i]);
         check($sformatf("%s grant%0d beats", tag, i), got_gb[i], exp_gb[i]);
      end
      check({tag, " ch_done count"}, got_done.size(), exp_done.size());
      for (int i = 0; i < exp_done.size() && i < got_done.size(); i++)
         check($sformatf("%s ch_done%0d id", tag, i), got_done[i], exp_done[i]);
      check({tag, " grant stable while waiting"}, stab_err, 0);
      check({tag, " burst_done to grant latency"}, lat_err, 0);
   endtask

   initial begin
      bit drained;
      int unsigned k, id, p, sz;
      int w;
      clear_inputs();
      AXI_areset = 1'b1;
      tick(); tick();
      do_reset();
      check_outputs_zero("reset");

      // S1: one channel, 40 beats at priority 2.
      drive_sample(3, 2, 40);
      exp_gch = '{3, 3, 3}; exp_gb = '{16, 16, 8}; exp_done = '{3};
      run_engine(1, 2, 0, 3, 0, 0, drained);
      check_run("S1", drained);
      check("S1 arbitrate to first grant", first_grant_cyc, 2);
      check("S1 drain one cycle after retire", drain_cyc, last_done_cyc + 1);

      // S2: priority order.
      do_reset();
      drive_sample(1, 1, 8); drive_sample(5, 7, 8);
      exp_gch = '{5, 1}; exp_gb = '{8, 8}; exp_done = '{5, 1};
      run_engine(1, 1, 0, 2, 0, 0, drained);
      check_run("S2", drained);
      check("S2 arbitrate to first grant", first_grant_cyc, 2);

      // S3: equal priorities alternate.
      do_reset();
      drive_sample(2, 3, 32); drive_sample(4, 3, 32);
      exp_gch = '{2, 4, 2, 4}; exp_gb = '{16, 16, 16, 16}; exp_done = '{2, 4};
      run_engine(1, 0, 0, 0, 0, 0, drained);
      check_run("S3", drained);

      // S4: zero-size descriptor retires without a grant.
      do_reset();
      drive_sample(6, 4, 0);
      exp_gch.delete(); exp_gb.delete(); exp_done = '{6};
      run_engine(1, 0, 0, 0, 0, 0, drained);
      check_run("S4", drained);
      check("S4 drain one cycle after retire", drain_cyc, last_done_cyc + 1);

      // S5: samples while ch3 is in WAIT_BURST; ch3 is left untouched.
      do_reset();
      drive_sample(3, 2, 40);
      exp_gch = '{3, 3, 3, 9}; exp_gb = '{16, 16, 8, 5}; exp_done = '{3, 9};
      run_engine(1, 0, 3, 4, 1, 0, drained);
      check_run("S5", drained);

      // S6: reset in GRANT, then arbitrate an empty table.
      do_reset();
      drive_sample(3, 2, 40);
      arbitrate = 1'b1; tick(); arbitrate = 1'b0;
      w = 0;
      while (!grant_valid && w < 10) begin tick(); w++; end
      check("S6 reached GRANT", grant_valid, 1);
      AXI_areset = 1'b1; tick(); AXI_areset = 1'b0;
      check_outputs_zero("S6 after reset");
      w = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (grant_valid || arbWriteTransactionsDone || ch_done) w++;
      end
      check("S6 stays idle without arbitrate", w, 0);
      for (int i = 0; i < NCH; i++) m_v[i] = 0;
      m_rr = 0;
      exp_gch.delete(); exp_gb.delete(); exp_done.delete();
      run_engine(1, 0, 0, 0, 0, 0, drained);
      check_run("S6", drained);

      // Vector table: range conflicts and overwrite of an existing entry.
      do_reset();
      vecs = '{'{40, 1, 4, 1}, '{63, 2, 5, 1}, '{31, 9, 20, 0},
               '{0, 2, 3, 0},  '{32, 15, 7, 1}, '{0, 5, 20, 0}};
      for (int i = 0; i < 6; i++) begin
         drive_sample(vecs[i].id, vecs[i].prio, vecs[i].size);
         check($sformatf("V%0d sample_conflict id%0d", i, vecs[i].id), sample_conflict, vecs[i].exp_conf);
         model_sample(vecs[i].id, vecs[i].prio, vecs[i].size);
      end
      model_run();
      run_engine(1, 2, 0, 3, 0, 1, drained);
      check_run("VT", drained);

      // Randomized runs; rr pointer carries over between runs.
      for (int r = 0; r < 8; r++) begin
         k = $urandom_range(6, 1);
         for (int s = 0; s < int'(k); s++) begin
            id = $urandom_range(35, 0);
            p  = $urandom_range(15, 0);
            sz = ($urandom_range(4, 0) == 0) ? 0 : $urandom_range(60, 1);
            drive_sample(id, p, sz);
            check($sformatf("R%0d sample%0d conflict", r, s), sample_conflict, (id >= NCH) ? 1 : 0);
            model_sample(id, p, sz);
         end
         model_run();
         run_engine(1, 3, 0, 4, 0, 1, drained);
         check_run($sformatf("R%0d", r), drained);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
